// File: rtl/lu_serial_sequencer_pkg.sv
// rtl/lu_serial_sequencer_pkg.sv - opcode constants and FSM state type for the serial sequencer
// Purpose: shared definitions for lu_serial_sequencer, its interface and its testbench.
// Ports: none (package).
package lu_pkg;

    localparam logic [1:0] LU_NAND = 2'b00;
    localparam logic [1:0] LU_AND  = 2'b01;
    localparam logic [1:0] LU_NOR  = 2'b10;
    localparam logic [1:0] LU_OR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/lu_serial_sequencer_if.sv
// rtl/lu_serial_sequencer_if.sv - command, response and logic-unit signal bundle
// Purpose: groups the command handshake, response handshake and logic-unit link.
// Ports: slave  = sequencer side (takes commands, drives the unit, returns results)
//        master = environment side (issues commands, models the unit, takes results)
interface lu_serial_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             lu_a;
    logic             lu_b;
    logic             lu_sel_group;
    logic             lu_sel_op;
    logic             lu_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, lu_y, rsp_ready,
        output cmd_ready, lu_a, lu_b, lu_sel_group, lu_sel_op, rsp_valid, rsp_data, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, lu_y, rsp_ready,
        input  cmd_ready, lu_a, lu_b, lu_sel_group, lu_sel_op, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/lu_serial_sequencer_shift_reg.sv
// rtl/lu_serial_sequencer_shift_reg.sv - result register with bit-position write
// Purpose: collects the logic unit's 1-bit results into a WIDTH-bit word.
// Ports: clk, rst_n (async active-low), i_clear (zero the word),
//        i_wr_en/i_pos/i_bit (write i_bit at position i_pos), o_data (assembled word).
module lu_shift_reg #(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic [CW-1:0]    i_pos,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_clear) begin
            r_data <= '0;
        end else if (i_wr_en) begin
            r_data[i_pos] <= i_bit;
        end
    end

    assign o_data = r_data;
endmodule

// File: rtl/lu_serial_sequencer.sv
// rtl/lu_serial_sequencer.sv - bit-serial command sequencer for the 1-bit logic unit
// Purpose: accepts {op, A, B}, drives the logic unit one bit per cycle LSB first,
//          gathers its result bits and returns the WIDTH-bit word.
// Ports: clk, rst_n (async active-low), bus (lu_serial_sequencer_if.slave):
//        cmd_* command handshake, lu_* logic-unit link, rsp_* response handshake, busy.
module lu_serial_sequencer
    import lu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lu_serial_sequencer_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_inc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_lu_a;
    logic             r_lu_b;
    logic             r_sel_group;
    logic             r_sel_op;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic             r_busy;
    logic             w_accept;
    logic             w_last;
    logic             w_shift;

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_last    = (r_cnt == LAST);
    assign w_shift   = (r_state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accept is gated by the registered cmd_ready so nothing is taken on the
    // first cycle after reset, when cmd_ready is still low.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so every output comes
    // straight from a flop. lu_a/lu_b are loaded one bit ahead: bit 0 at accept,
    // bit cnt+1 while bit cnt is being sampled, and 0 once the last bit is done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_lu_a      <= 1'b0;
            r_lu_b      <= 1'b0;
            r_sel_group <= 1'b0;
            r_sel_op    <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
            if (w_accept) begin
                r_a         <= bus.cmd_a;
                r_b         <= bus.cmd_b;
                r_sel_group <= bus.cmd_op[1];
                r_sel_op    <= bus.cmd_op[0];
                r_cnt       <= '0;
                r_lu_a      <= bus.cmd_a[0];
                r_lu_b      <= bus.cmd_b[0];
            end else if (w_shift) begin
                r_cnt  <= w_cnt_inc;
                r_lu_a <= w_last ? 1'b0 : r_a[w_cnt_inc];
                r_lu_b <= w_last ? 1'b0 : r_b[w_cnt_inc];
            end
        end
    end

    lu_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_accept),
        .i_wr_en (w_shift),
        .i_pos   (r_cnt),
        .i_bit   (bus.lu_y),
        .o_data  (bus.rsp_data)
    );

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.busy         = r_busy;
    assign bus.lu_a         = r_lu_a;
    assign bus.lu_b         = r_lu_b;
    assign bus.lu_sel_group = r_sel_group;
    assign bus.lu_sel_op    = r_sel_op;
endmodule

// File: doc/lu_serial_sequencer.md
# lu_serial_sequencer

Bit-serial command sequencer for the 1-bit AND/NAND/OR/NOR logic unit. It accepts a WIDTH-bit logic command (opcode plus two operands) over a valid/ready handshake. It then drives the logic unit one bit per cycle (LSB first), captures the unit's 1-bit result each cycle into a shift register, and returns the assembled WIDTH-bit result over a second valid/ready handshake. It sits on both sides of the logic unit: it feeds the unit's A/B/select inputs and consumes its Y output.

## Interface
- WIDTH, default 8: operand and result width in bits. Legal values are WIDTH >= 2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  the block accepts a command this cycle.
- cmd_op  input  2  operation code {sel_group, sel_op}: 00 NAND, 01 AND, 10 NOR, 11 OR.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- lu_a  output  1  current bit of A, to the logic unit.
- lu_b  output  1  current bit of B, to the logic unit.
- lu_sel_group  output  1  cmd_op[1], to the logic unit.
- lu_sel_op  output  1  cmd_op[0], to the logic unit.
- lu_y  input  1  logic unit result. Combinational from lu_a, lu_b, lu_sel_group and lu_sel_op.
- rsp_valid  output  1  the result is available.
- rsp_ready  input  1  the consumer takes the result.
- rsp_data  output  WIDTH  assembled result.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
    - latch cmd_op, cmd_a and cmd_b;
    - clear the bit counter to 0;
    - go to SHIFT.
  - SHIFT: cmd_ready=0. On each cycle:
    - lu_a/lu_b present bit[cnt] of the latched operands;
    - at the clock edge, lu_y is shifted into the result register at position cnt, and cnt increments;
    - the cycle with cnt==WIDTH-1 completes the op and the FSM goes to DONE.
  - DONE: rsp_valid=1 and rsp_data holds the result. On rsp_valid&&rsp_ready go to IDLE.
- Output values per state:
  - lu_sel_group/lu_sel_op are registered from the latched opcode and hold their value through IDLE until the next accept.
  - lu_a/lu_b are 0 in IDLE and DONE.
- Commands are never queued. cmd_valid outside IDLE is ignored, and no state is touched.
- rsp_data is stable while rsp_valid=1 and rsp_ready=0. It keeps its value after the handshake until the next result overwrites it.
- Bit counter width is $clog2(WIDTH). It needs no wrap beyond WIDTH-1 because the FSM leaves SHIFT there.
- Reset values, all 0: cmd_ready, rsp_valid, busy, rsp_data, lu_a, lu_b, lu_sel_group, lu_sel_op. The FSM resets to IDLE. cmd_ready becomes 1 on the first cycle after reset is released.
- Reset mid-operation (SHIFT or DONE) aborts the op immediately. No response is produced and all outputs go to their reset values.

## Timing
- Accept edge E0: lu_a/lu_b for bit 0 are valid after E0, so they are registered outputs.
- Bit i is driven between edges E(i) and E(i+1). lu_y is sampled at edge E(i+1).
- rsp_valid rises after edge E(WIDTH), i.e. exactly WIDTH cycles after accept.
- Response handshake at edge R: cmd_ready is 1 after R, so the next accept can happen at R+1.
- Minimum command period is WIDTH+2 cycles (WIDTH in SHIFT, 1 in DONE, 1 in IDLE).
- No combinational path from cmd_* or rsp_ready to any output except through the state registers.

## Structure
- Shared package lu_pkg holds:
  - opcode constants: LU_NAND=2'b00, LU_AND=2'b01, LU_NOR=2'b10, LU_OR=2'b11;
  - the FSM state typedef (IDLE, SHIFT, DONE).
- One natural sub-module, lu_shift_reg: a WIDTH-bit register with a load/clear input and a bit-position write of lu_y, indexed by cnt.
- The logic unit itself is instantiated only in the testbench, beside this block, not inside it.

## Test plan
- WIDTH=8, AND (op 01), A=0xF0, B=0xCC -> rsp_data=0xC0. rsp_valid rises exactly 8 cycles after the accept edge.
- NAND (op 00) A=0xF0 B=0xCC -> 0x3F. NOR (op 10) A=0xA5 B=0x0F -> 0x50. OR (op 11) same operands -> 0xAF. Run the four back-to-back at minimum period, 10 cycles each.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid=1, rsp_data constant and cmd_ready=0 throughout. Raise rsp_ready -> IDLE on the next cycle.
- Busy injection: assert cmd_valid with different operands during SHIFT -> ignored, and the result still matches the first command.
- Reset mid-op: assert rst_n=0 while cnt=3 -> all outputs 0 asynchronously and no rsp_valid. After release, a new AND 0xFF/0x81 -> 0x81.
- Reset state: immediately after reset release -> cmd_ready=1, busy=0, rsp_valid=0, all lu_* outputs 0.
